// File: rtl/pwm_pkg.sv
// pwm_pkg: shared decoder state encoding and default duty width.
package pwm_pkg;
  localparam int PWM_WIDTH_DEFAULT = 4;
  typedef enum logic [1:0] {HUNT, MEASURE, LOW} pwm_dec_state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous pin, async active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the duty of each PWM period sampled on step strobes.
// Optional 3-tap glitch filter after the synchronizer: PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int N = PWM_WIDTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         pwm_in,
  output logic [N-1:0] duty,
  output logic         valid,
  output logic         err,
  output logic         locked
);
  localparam logic [N:0] FULL = {1'b1, {N{1'b0}}};
  localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};
  logic s_raw, s_sync, rise, prev_q, valid_q, err_q, locked_q;
  logic [N:0] per_q, hi_q, run_q, run_d;
  logic [N-1:0] duty_q;
  pwm_dec_state_t state_q;
  sync_2ff u_sync (.clk(clk), .rst_n(rst), .d_i(pwm_in), .q_o(s_raw));
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [1:0] tap_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tap_q <= '0;
    else tap_q <= {tap_q[0], s_raw};
  assign s_sync = (s_raw & tap_q[0]) | (s_raw & tap_q[1]) | (tap_q[0] & tap_q[1]);
`else
  assign s_sync = s_raw;
`endif
  assign rise  = s_sync & ~prev_q;
  assign run_d = (s_sync == prev_q) ? run_q + ONE : ONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      prev_q   <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      run_q    <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else if (!ena) begin
      state_q  <= HUNT;
      prev_q   <= 1'b0;
      per_q    <= '0;
      hi_q     <= '0;
      run_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (step) begin
        prev_q <= s_sync;
        case (state_q)
          HUNT:
            if (rise) begin
              per_q    <= ONE;
              hi_q     <= ONE;
              state_q  <= MEASURE;
              locked_q <= 1'b1;
            end else if (run_d == FULL) begin
              run_q <= '0;
              if (s_sync) err_q <= 1'b1;
              else begin
                duty_q   <= '0;
                valid_q  <= 1'b1;
                state_q  <= LOW;
                locked_q <= 1'b1;
              end
            end else run_q <= run_d;
          MEASURE:
            if (rise) begin
              per_q <= ONE;
              hi_q  <= ONE;
              if (per_q == FULL) begin
                duty_q  <= N'(hi_q);
                valid_q <= 1'b1;
              end else err_q <= 1'b1;
            end else if (per_q == FULL) begin
              // A full period with no closing rise: either duty 0 follows or the input is stuck high
              if (s_sync) begin
                err_q    <= 1'b1;
                state_q  <= HUNT;
                locked_q <= 1'b0;
                run_q    <= '0;
              end else begin
                duty_q  <= N'(hi_q);
                valid_q <= 1'b1;
                run_q   <= ONE;
                state_q <= LOW;
              end
            end else begin
              per_q <= per_q + ONE;
              hi_q  <= hi_q + {{N{1'b0}}, s_sync};
            end
          default:
            if (rise) begin
              per_q   <= ONE;
              hi_q    <= ONE;
              state_q <= MEASURE;
            end else if (run_q + ONE == FULL) begin
              duty_q  <= '0;
              valid_q <= 1'b1;
              run_q   <= '0;
            end else run_q <= run_q + ONE;
        endcase
      end
    end
  end
  assign duty   = duty_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed bench driving a behavioural N=4 PWM stream into pwm_decoder.
module tb_pwm_decoder;
  logic clk = 1'b0, rst = 1'b0, ena = 1'b0, step = 1'b0, pwm_in = 1'b0;
  logic [3:0] duty;
  logic valid, err, locked;
  int tests = 0, fails = 0, nv = 0, ne = 0, both = 0;
  int sweep[3] = '{1, 8, 15};

  always #5 clk = ~clk;

  pwm_decoder #(.N(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .pwm_in(pwm_in),
    .duty(duty), .valid(valid), .err(err), .locked(locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Level changes at the transmitter step, the decoder samples it on the next step
  task automatic tick(input logic lvl);
    pwm_in = lvl;
    repeat (4) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    if (valid) nv++;
    if (err) ne++;
    if (valid && err) both++;
  endtask

  task automatic period(input int d, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < 16; i++) tick(i < d);
  endtask

  task automatic clr();
    nv = 0;
    ne = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked, 0);
    rst = 1'b1;
    ena = 1'b1;
    @(negedge clk);
    clr();
    period(5, 3);
    chk("d5_duty", duty, 5);
    chk("d5_nvalid", nv, 2);
    chk("d5_nerr", ne, 0);
    chk("d5_locked", locked, 1);
    for (int k = 0; k < 3; k++) begin
      clr();
      period(sweep[k], 2);
      chk("sweep_duty", duty, sweep[k]);
      chk("sweep_nvalid", nv, 2);
      chk("sweep_nerr", ne, 0);
    end
    clr();
    period(0, 2);
    chk("d0_duty", duty, 0);
    chk("d0_nvalid", nv, 3);
    chk("d0_nerr", ne, 0);
    chk("d0_locked", locked, 1);
    clr();
    period(9, 2);
    chk("d9_duty", duty, 9);
    chk("d9_nvalid", nv, 1);
    chk("d9_nerr", ne, 0);
    tick(1'b1);
    clr();
    repeat (39) tick(1'b1);
    chk("stuck_nerr", ne, 2);
    chk("stuck_nvalid", nv, 0);
    chk("stuck_locked", locked, 0);
    clr();
    period(7, 3);
    chk("relock_duty", duty, 7);
    chk("relock_nvalid", nv, 1);
    chk("relock_nerr", ne, 0);
    clr();
    for (int i = 0; i < 16; i++) tick(i < 3 || i == 6);
    chk("glitch_nerr", ne, 1);
    chk("glitch_nvalid", nv, 1);
    clr();
    period(3, 2);
    chk("resync_nerr", ne, 1);
    chk("resync_nvalid", nv, 1);
    chk("resync_duty", duty, 3);
    for (int i = 0; i < 5; i++) tick(i < 3);
    ena = 1'b0;
    @(negedge clk);
    chk("ena_locked", locked, 0);
    chk("ena_duty_hold", duty, 3);
    clr();
    tick(1'b1);
    chk("ena_step_nerr", ne, 0);
    chk("ena_step_nvalid", nv, 0);
    chk("ena_step_locked", locked, 0);
    ena = 1'b1;
    clr();
    period(4, 2);
    chk("reena_duty", duty, 4);
    chk("reena_nvalid", nv, 1);
    chk("reena_nerr", ne, 0);
    for (int i = 0; i < 8; i++) tick(i < 6);
    #2 rst = 1'b0;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_locked", locked, 0);
    chk("arst_valid", valid, 0);
    chk("arst_err", err, 0);
    pwm_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clr();
    period(6, 2);
    chk("post_rst_duty", duty, 6);
    chk("post_rst_nvalid", nv, 1);
    chk("post_rst_nerr", ne, 0);
    chk("valid_err_excl", both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
